// File: rtl/systolic_drain.sv
// Result drain for the systolic array: snapshots every PE result on `done`,
// converts each to FP16 and streams them out over a valid/ready handshake.
module systolic_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int N         = 2,
  parameter int FRAC_BITS = 10,
  localparam int NE       = N * N,
  localparam int IW       = (NE > 1) ? $clog2(NE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [NE*5-1:0]         exp_in,
  input  logic [NE*ACC_WIDTH-1:0] acc_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic [IW-1:0]           out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_snap;
  logic                   w_load;
  logic                   w_accept;
  logic [IW-1:0]          r_cnt;
  logic [4:0]             r_exp [NE];
  logic [ACC_WIDTH-1:0]   r_acc [NE];
  logic [4:0]             w_exp_in [NE];
  logic [ACC_WIDTH-1:0]   w_acc_in [NE];
  logic                   r_out_valid;
  logic [15:0]            r_out_data;
  logic [IW-1:0]          r_out_idx;
  logic                   r_out_last;
  logic                   r_overrun;
  logic [15:0]            w_conv;

  for (genvar gi = 0; gi < NE; gi++) begin : g_unpack
    assign w_exp_in[gi] = exp_in[5*gi +: 5];
    assign w_acc_in[gi] = acc_in[ACC_WIDTH*gi +: ACC_WIDTH];
  end

  // Sign-magnitude normalisation to FP16: truncating mantissa, saturate on
  // exponent overflow, flush to signed zero on underflow (no subnormals).
  function automatic logic [15:0] f_to_fp16(input logic [4:0] e,
                                            input logic [ACC_WIDTH-1:0] a);
    logic                 sign;
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] norm;
    logic [9:0]           mant;
    int                   p;
    int                   ee;
    sign = a[ACC_WIDTH-1];
    mag  = sign ? (~a + 1'b1) : a;
    p    = 0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag[i]) p = i;
    end
    norm = mag << (ACC_WIDTH - 1 - p);
    mant = 10'(norm >> (ACC_WIDTH - 11));
    ee   = int'(e) + p - FRAC_BITS;
    if (mag == '0)      return 16'h0000;
    else if (ee >= 31)  return {sign, 15'h7BFF};
    else if (ee <= 0)   return {sign, 15'h0000};
    else                return {sign, 5'(ee), mant};
  endfunction

  assign w_conv = f_to_fp16(r_exp[r_cnt], r_acc[r_cnt]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_snap       = 1'b0;
    w_load       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (done) begin
          w_snap       = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        w_load       = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        if (r_out_valid && out_ready) begin
          w_accept     = 1'b1;
          w_state_next = (r_cnt == LAST_IDX) ? S_IDLE : S_CONV;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NE; i++) begin
        r_exp[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      if (w_snap) begin
        r_cnt <= '0;
        for (int i = 0; i < NE; i++) begin
          r_exp[i] <= w_exp_in[i];
          r_acc[i] <= w_acc_in[i];
        end
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_conv;
        r_out_idx   <= r_cnt;
        r_out_last  <= (r_cnt == LAST_IDX);
      end
      if (w_accept) begin
        r_out_valid <= 1'b0;
        if (r_cnt != LAST_IDX) r_cnt <= r_cnt + 1'b1;
      end
      // Includes the SEND->IDLE edge: a done there is still treated as busy.
      if (done && r_state != S_IDLE) r_overrun <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: expected FP16 words are queued when a
// drain is launched and popped as the DUT hands each word over.
module tb_systolic_drain;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int NE = N * N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             done = 1'b0;
  logic             out_ready = 1'b1;
  logic [NE*5-1:0]  exp_in = '0;
  logic [NE*AW-1:0] acc_in = '0;
  logic             out_valid;
  logic [15:0]      out_data;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             busy;
  logic             overrun;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   bcyc;

  systolic_drain #(.ACC_WIDTH(AW), .N(N), .FRAC_BITS(10)) dut (
    .clk(clk), .rst(rst), .done(done), .exp_in(exp_in), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_pe(input int i, input logic [4:0] e, input logic [31:0] a);
    exp_in[5*i +: 5]   = e;
    acc_in[AW*i +: AW] = a;
  endtask

  task automatic load_basic();
    set_pe(0, 5'd15, 32'd1024);
    set_pe(1, 5'd15, 32'd2048);
    set_pe(2, 5'd15, 32'hFFFF_FC00);
    set_pe(3, 5'd15, 32'd3072);
  endtask

  task automatic push4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    sb.push_back('{d: a, idx: 2'd0});
    sb.push_back('{d: b, idx: 2'd1});
    sb.push_back('{d: c, idx: 2'd2});
    sb.push_back('{d: d, idx: 2'd3});
  endtask

  // Called on a falling edge; returns on the falling edge after the sampling edge.
  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic drain(input int stall_idx, input int stall_n, input int ovr_idx,
                       input int stop_idx, input bit timing, output int busy_cycles);
    int   stalled = 0;
    int   nacc = 0;
    bit   ovr_sent = 1'b0;
    bit   fin = 1'b0;
    exp_t e;
    busy_cycles = 0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      done = 1'b0;
      if (busy) busy_cycles++;
      if (out_valid) begin
        if (stop_idx >= 0 && int'(out_idx) == stop_idx) begin
          out_ready = 1'b0;
          fin = 1'b1;
        end else if (int'(out_idx) == stall_idx && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
          if (sb.size() > 0) begin
            chk("stall_data", out_data, sb[0].d);
            chk("stall_idx", out_idx, sb[0].idx);
          end
        end else begin
          out_ready = 1'b1;
          if (sb.size() == 0) begin
            chk("extra_word_idx", out_idx, 32'd4);
          end else begin
            e = sb.pop_front();
            chk("data", out_data, e.d);
            chk("idx", out_idx, e.idx);
            chk("last", out_last, e.idx == 2'd3);
            if (timing) chk("accept_cycle", cyc, 1 + 2*nacc);
            nacc++;
          end
          if (int'(out_idx) == ovr_idx && !ovr_sent) begin
            done = 1'b1;
            ovr_sent = 1'b1;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
      if (!fin && sb.size() == 0 && !busy && cyc > 0) fin = 1'b1;
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      chk("timeout_left", sb.size(), 0);
      chk("timeout_busy", busy, 0);
    end
    done = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // Basic drain with ready tied high
    load_basic();
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);
    chk("basic_busy_cycles", bcyc, 8);

    // Backpressure on idx 1
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(1, 5, -1, -1, 1'b0, bcyc);
    chk("bp_busy_cycles", bcyc, 13);

    // Edge values, set 1
    set_pe(0, 5'd15, 32'd0);
    set_pe(1, 5'd15, 32'd1);
    set_pe(2, 5'd15, 32'h7FFF_FFFF);
    set_pe(3, 5'd0,  32'd1);
    push4(16'h0000, 16'h1400, 16'h7BFF, 16'h0000);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);

    // Edge values, set 2: most negative, negative flush, full mantissa, negative
    set_pe(0, 5'd0,  32'h8000_0000);
    set_pe(1, 5'd10, 32'hFFFF_FFFF);
    set_pe(2, 5'd10, 32'd2047);
    set_pe(3, 5'd20, 32'hFFFF_F400);
    push4(16'hD400, 16'h8000, 16'h2BFF, 16'hD600);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);

    // Edge values, set 3: exponent boundaries E=31, 30, 0, 1
    set_pe(0, 5'd31, 32'd1024);
    set_pe(1, 5'd30, 32'd1024);
    set_pe(2, 5'd10, 32'd1);
    set_pe(3, 5'd11, 32'd1);
    push4(16'h7BFF, 16'h7800, 16'h0000, 16'h0400);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);

    // Snapshot isolation: inputs change right after done
    load_basic();
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    for (int i = 0; i < NE; i++) set_pe(i, 5'd3, 32'h1234_5678 + i);
    drain(-1, 0, -1, -1, 1'b1, bcyc);

    // Overrun during idx 1
    chk("ovr_pre", overrun, 0);
    load_basic();
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, 1, -1, 1'b1, bcyc);
    chk("ovr_set", overrun, 1);
    repeat (4) @(negedge clk);
    chk("ovr_no_restart_busy", busy, 0);
    chk("ovr_no_restart_valid", out_valid, 0);
    chk("ovr_sticky", overrun, 1);

    // A done in IDLE afterwards drains normally
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);
    chk("ovr_still_set", overrun, 1);

    // Reset during SEND of idx 2
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, -1, 2, 1'b1, bcyc);
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, -1, -1, 1'b1, bcyc);
    chk("restart_busy_cycles", bcyc, 8);

    // done on the same edge as the final handshake
    push4(16'h3C00, 16'h4000, 16'hBC00, 16'h4200);
    pulse_done();
    drain(-1, 0, 3, -1, 1'b1, bcyc);
    chk("last_edge_ovr", overrun, 1);
    repeat (3) @(negedge clk);
    chk("last_edge_busy", busy, 0);
    chk("last_edge_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
